cpu_mem_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the CPU's instruction-fetch port and its data port. It turns each pipeline step's fetch and data access into sequential SRAM cycles and holds IM_stall/DM_stall high until both results are collected. It then releases both stalls together for exactly one cycle, so the CPU pipeline advances in lockstep. It sits between the CPU core and the unified memory macro, in place of separate IM/DM memories.

---
 rtl/cpu_mem_arb_pkg.sv | 7 +
 rtl/cpu_mem_arbiter.sv | 79 +++++++
 tb/tb_cpu_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg: shared types and constants for the CPU memory arbiter
package cpu_mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RESP, S_REL} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
  localparam logic [3:0] BWEB_NONE = 4'hF;
  localparam logic CEB_OFF = 1'b1;
endpackage

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises fetch and data accesses onto one SRAM and releases both stalls in lockstep
module cpu_mem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_bweb,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_di,
  output logic [31:0]       im_instr,
  output logic              im_stall,
  output logic [31:0]       dm_do,
  output logic              dm_stall,
  output logic              mem_ceb,
  output logic              mem_web,
  output logic [3:0]        mem_bweb,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);
  import cpu_mem_arb_pkg::*;
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [31:0] im_instr_q, im_instr_d, dm_do_q, dm_do_d;
  logic resp, rel, dm_pick, if_pick, issue, go, st;
  logic unused_addr;
  // retire the answered access, then pick the next one (DM first: older instruction)
  always_comb begin
    resp = state_q == S_RESP;
    rel = state_q == S_REL;
    if_done_d = !rel & (if_done_q | (resp & owner_q == OWN_IF));
    dm_done_d = !rel & (dm_done_q | (resp & owner_q == OWN_DM));
    im_instr_d = resp & owner_q == OWN_IF ? mem_do : im_instr_q;
    dm_do_d = resp & owner_q == OWN_DM & !dm_we ? mem_do : dm_do_q;
    dm_pick = !rel & dm_req & !dm_done_d;
    if_pick = !rel & !dm_pick & if_req & !if_done_d;
    issue = dm_pick | if_pick;
    owner_d = !issue ? owner_q : dm_pick ? OWN_DM : OWN_IF;
    state_d = rel ? S_IDLE : issue ? S_RESP : resp ? S_REL : S_IDLE;
  end
  // SRAM command mux; quiet while in reset so nothing is issued
  always_comb begin
    go = issue & !rst;
    st = go & dm_pick & dm_we;
    mem_ceb = go ? 1'b0 : CEB_OFF;
    mem_a = !go ? '0 : dm_pick ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
    mem_web = !st;
    mem_bweb = st ? dm_bweb : BWEB_NONE;
    mem_di = st ? dm_di : '0;
  end
  // state and result registers; reset drops any in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      im_instr_q <= '0;
      dm_do_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if_done_q <= if_done_d;
      dm_done_q <= dm_done_d;
      im_instr_q <= im_instr_d;
      dm_do_q <= dm_do_d;
    end
  end
  assign im_stall = if_req & (state_q != S_REL) & !rst;
  assign dm_stall = dm_req & (state_q != S_REL) & !rst;
  assign im_instr = im_instr_q;
  assign dm_do = dm_do_q;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2], dm_addr[1:0]};
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed checks of the arbiter against a behavioural SRAM
module tb_cpu_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_di = 0;
  logic [3:0] dm_bweb = 4'hF;
  logic [31:0] im_instr, dm_do, mem_di, mem_do;
  logic im_stall, dm_stall, mem_ceb, mem_web;
  logic [3:0] mem_bweb;
  logic [13:0] mem_a;
  logic [31:0] mem [0:16383];
  int nvec = 0, nerr = 0;

  cpu_mem_arbiter #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_bweb(dm_bweb), .dm_addr(dm_addr), .dm_di(dm_di),
    .im_instr(im_instr), .im_stall(im_stall), .dm_do(dm_do), .dm_stall(dm_stall),
    .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_bweb(mem_bweb), .mem_a(mem_a),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_ceb) begin
      if (!mem_web)
        for (int b = 0; b < 4; b++)
          if (!mem_bweb[b]) mem[mem_a][8*b +: 8] <= mem_di[8*b +: 8];
      mem_do <= mem[mem_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_0055;
    mem[2] = 32'h0000_0093;
    mem[4] = 32'h0000_0013;
    mem[8] = 32'hAABB_CCDD;
    mem[16] = 32'hDEAD_BEEF;
    mem_do = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_im_instr", im_instr, 0);
    chk("rst_dm_do", dm_do, 0);
    chk("rst_im_stall", im_stall, 0);
    chk("rst_dm_stall", dm_stall, 0);
    chk("rst_ceb", mem_ceb, 1);
    chk("rst_web", mem_web, 1);
    chk("rst_bweb", mem_bweb, 4'hF);
    chk("rst_a", mem_a, 0);
    chk("rst_di", mem_di, 0);
    cyc(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ceb", mem_ceb, 1);
      chk("idle_stalls", {im_stall, dm_stall}, 0);
      cyc();
    end
    if_req = 1; if_addr = 32'h0000_0010;
    @(negedge clk);
    chk("f_c0_stall", im_stall, 1);
    chk("f_c0_a", mem_a, 4);
    chk("f_c0_ceb", mem_ceb, 0);
    chk("f_c0_web", mem_web, 1);
    cyc(); @(negedge clk);
    chk("f_c1_stall", im_stall, 1);
    chk("f_c1_ceb", mem_ceb, 1);
    cyc(); @(negedge clk);
    chk("f_c2_stall", im_stall, 0);
    chk("f_c2_instr", im_instr, 32'h13);
    cyc(); if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    @(negedge clk);
    chk("r_c0_ceb", mem_ceb, 0);
    chk("r_c0_a", mem_a, 14'h10);
    chk("r_c0_stall", dm_stall, 1);
    cyc(); rst = 1;
    @(negedge clk);
    chk("r_rst_stall", dm_stall, 0);
    chk("r_rst_ceb", mem_ceb, 1);
    cyc(); @(negedge clk);
    chk("r_rst_dm_do", dm_do, 0);
    chk("r_rst_stall2", {im_stall, dm_stall}, 0);
    cyc(); rst = 0;
    @(negedge clk);
    chk("r_idle_ceb", mem_ceb, 0);
    chk("r_idle_a", mem_a, 14'h10);
    chk("r_idle_stall", dm_stall, 1);
    cyc(); cyc(); @(negedge clk);
    chk("r_done_stall", dm_stall, 0);
    chk("r_done_do", dm_do, 32'hDEAD_BEEF);
    cyc(); if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    chk("lf_c0_a", mem_a, 14'h10);
    chk("lf_c0_ceb", mem_ceb, 0);
    chk("lf_c0_stalls", {im_stall, dm_stall}, 2'b11);
    cyc(); @(negedge clk);
    chk("lf_c1_a", mem_a, 2);
    chk("lf_c1_ceb", mem_ceb, 0);
    chk("lf_c1_do", dm_do, 32'hDEAD_BEEF);
    chk("lf_c1_stalls", {im_stall, dm_stall}, 2'b11);
    cyc(); @(negedge clk);
    chk("lf_c2_ceb", mem_ceb, 1);
    chk("lf_c2_stalls", {im_stall, dm_stall}, 2'b11);
    cyc(); @(negedge clk);
    chk("lf_c3_stalls", {im_stall, dm_stall}, 2'b00);
    chk("lf_c3_instr", im_instr, 32'h93);
    cyc(); if_req = 0; dm_we = 1; dm_bweb = 4'b1100; dm_di = 32'h1234_5678; dm_addr = 32'h20;
    @(negedge clk);
    chk("st_c0_web", mem_web, 0);
    chk("st_c0_bweb", mem_bweb, 4'b1100);
    chk("st_c0_a", mem_a, 8);
    chk("st_c0_di", mem_di, 32'h1234_5678);
    cyc(); @(negedge clk);
    chk("st_c1_web", mem_web, 1);
    chk("st_c1_stall", dm_stall, 1);
    cyc(); @(negedge clk);
    chk("st_c2_web", mem_web, 1);
    chk("st_c2_stall", dm_stall, 0);
    chk("st_c2_do", dm_do, 32'hDEAD_BEEF);
    cyc(); dm_we = 0; dm_bweb = 4'hF;
    @(negedge clk);
    chk("ld_c0_a", mem_a, 8);
    chk("ld_c0_web", mem_web, 1);
    cyc(); cyc(); @(negedge clk);
    chk("ld_c2_do", dm_do, 32'hAABB_5678);
    cyc(); dm_req = 0; if_req = 1; if_addr = 32'h0001_0004;
    @(negedge clk);
    chk("al_c0_a", mem_a, 1);
    cyc(); cyc(); @(negedge clk);
    chk("al_c2_stall", im_stall, 0);
    chk("al_c2_instr", im_instr, 32'h55);
    cyc(); if_req = 0;
    @(negedge clk);
    chk("end_ceb", mem_ceb, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
